// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Central stall/flush controller for the 5-stage pipeline. Detects
//   load-use hazards, taken-branch redirects and data-memory wait states,
//   and drives the hold/bubble controls of the pipeline registers. Also
//   keeps a memory-timeout watchdog and saturating performance counters.
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   id_*                  : source registers / usage of the ID instruction
//   ex_*                  : destination / load / write / branch info from EX
//   mem_req, mem_ready    : data-memory handshake of the MEM instruction
//   pc_stall .. memwb_bubble : combinational pipeline controls
//   mem_timeout           : sticky watchdog flag
//   stall_cycles, flush_events : saturating performance counters
module hazard_control_unit #(
  parameter int BRANCH_PENALTY = 1,
  parameter int MEM_TIMEOUT    = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_address,
  input  logic [4:0]       id_rs2_address,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_address,
  input  logic             ex_MemRead,
  input  logic             ex_RegWrite,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [7:0] TMO    = 8'(MEM_TIMEOUT);
  localparam logic [3:0] PEN_M1 = 4'(BRANCH_PENALTY - 1);

  state_t     state;
  logic [3:0] flush_cnt;
  logic [7:0] wait_cnt;
  logic       expired;   // watchdog already fired during the current wait

  logic load_use, mem_wait, mem_hold, tmo_fire, branch_act;

  assign load_use = ex_MemRead & ex_RegWrite & (ex_rd_address != 5'd0) &
                    ((id_uses_rs1 & (id_rs1_address == ex_rd_address)) |
                     (id_uses_rs2 & (id_rs2_address == ex_rd_address)));
  assign mem_wait = mem_req & ~mem_ready;
  assign mem_hold = mem_wait & (wait_cnt < TMO);
  // Only the first saturated cycle of a wait counts as the timeout event.
  assign tmo_fire = mem_wait & (wait_cnt == TMO) & ~expired;
  // A branch seen under a memory hold is re-presented by the frozen stages.
  assign branch_act = ~reset & ~mem_hold & ex_branch_taken;

  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    if (!reset) begin
      if (mem_hold) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
      end else begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (state == FLUSH) begin
          ifid_flush = 1'b1;
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
        // Released-by-timeout access must not write back.
        memwb_bubble = tmo_fire;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      flush_cnt    <= '0;
      wait_cnt     <= '0;
      expired      <= 1'b0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (mem_wait) begin
        if (wait_cnt < TMO) wait_cnt <= wait_cnt + 8'd1;
        if (tmo_fire) expired <= 1'b1;
      end else begin
        wait_cnt <= '0;
        expired  <= 1'b0;
      end
      if (tmo_fire) mem_timeout <= 1'b1;

      if (!mem_hold) begin
        if (ex_branch_taken) begin
          if (BRANCH_PENALTY > 1) begin
            state     <= FLUSH;
            flush_cnt <= PEN_M1;
          end else begin
            state <= RUN;
          end
        end else if (state == FLUSH) begin
          if (flush_cnt <= 4'd1) state <= RUN;
          else flush_cnt <= flush_cnt - 4'd1;
        end
      end

      if (pc_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (branch_act && (flush_events != '1)) flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1_address, id_rs2_address, ex_rd_address;
  logic id_uses_rs1, id_uses_rs2, ex_MemRead, ex_RegWrite, ex_branch_taken;
  logic mem_req, mem_ready;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic exmem_stall, memwb_bubble, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.BRANCH_PENALTY(3), .MEM_TIMEOUT(8), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_address(ex_rd_address), .ex_MemRead(ex_MemRead),
    .ex_RegWrite(ex_RegWrite), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .memwb_bubble(memwb_bubble),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble}
  logic [6:0] ctl;
  assign ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                exmem_stall, memwb_bubble};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_FL   = 7'b0010000;
  localparam logic [6:0] C_HOLD = 7'b1101011;
  localparam logic [6:0] C_BUB  = 7'b0000001;

  task automatic idle();
    id_rs1_address = 0; id_rs2_address = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd_address = 0; ex_MemRead = 0; ex_RegWrite = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    @(negedge clk);
    ex_branch_taken = 1; ex_MemRead = 1; ex_RegWrite = 1; ex_rd_address = 7;
    id_rs1_address = 7; id_uses_rs1 = 1; mem_req = 1;
    #1;
    checks++;
    if (ctl !== C_NONE) begin errors++; $display("FAIL reset_ctl_during: got %b want %b", ctl, C_NONE); end
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (ctl !== C_NONE || mem_timeout !== 1'b0 || stall_cycles !== '0 || flush_events !== '0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b to=%b sc=%0d fe=%0d want 0/0/0/0", ctl, mem_timeout, stall_cycles, flush_events);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ex_MemRead = 1; ex_RegWrite = 1; ex_rd_address = 5;
    id_rs1_address = 5; id_uses_rs1 = 1; id_rs2_address = 2; id_uses_rs2 = 1;
    #1;
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL load_use_rs1: got %b want %b", ctl, C_LU); end
    @(negedge clk);
    ex_MemRead = 0; ex_RegWrite = 0; ex_rd_address = 0;   // bubble now in EX
    #1;
    checks++;
    if (ctl !== C_NONE) begin errors++; $display("FAIL load_use_after: got %b want %b", ctl, C_NONE); end
    checks++;
    if (stall_cycles !== 4'd1) begin errors++; $display("FAIL load_use_count: got %0d want 1", stall_cycles); end
    // rs2 match
    @(negedge clk);
    ex_MemRead = 1; ex_RegWrite = 1; ex_rd_address = 9;
    id_rs1_address = 3; id_rs2_address = 9;
    #1;
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL load_use_rs2: got %b want %b", ctl, C_LU); end
    // register matches but ID does not read it
    @(negedge clk);
    id_uses_rs2 = 0;
    #1;
    checks++;
    if (ctl !== C_NONE) begin errors++; $display("FAIL load_use_unused: got %b want %b", ctl, C_NONE); end
    // non-load writer does not stall
    @(negedge clk);
    id_uses_rs2 = 1; ex_MemRead = 0;
    #1;
    checks++;
    if (ctl !== C_NONE) begin errors++; $display("FAIL load_use_alu: got %b want %b", ctl, C_NONE); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (stall_cycles !== 4'd2) begin errors++; $display("FAIL load_use_count2: got %0d want 2", stall_cycles); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    ex_MemRead = 1; ex_RegWrite = 1; ex_rd_address = 0;
    id_rs1_address = 0; id_uses_rs1 = 1;
    #1;
    checks++;
    if (ctl !== C_NONE) begin errors++; $display("FAIL x0_no_stall: got %b want %b", ctl, C_NONE); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_branch();
    logic [6:0] exp [4] = '{C_BR, C_FL, C_FL, C_NONE};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ex_branch_taken = (i == 0);
      #1;
      checks++;
      if (ctl !== exp[i]) begin errors++; $display("FAIL branch_cyc%0d: got %b want %b", i, ctl, exp[i]); end
    end
    checks++;
    if (flush_events !== 4'd1) begin errors++; $display("FAIL branch_count: got %0d want 1", flush_events); end
  endtask

  task automatic test_mem_wait();
    logic [6:0] exp;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_req = (i < 5);
      mem_ready = (i == 4);
      ex_branch_taken = (i < 5);
      exp = (i < 4) ? C_HOLD : (i == 4) ? C_BR : (i < 7) ? C_FL : C_NONE;
      #1;
      checks++;
      if (ctl !== exp) begin errors++; $display("FAIL mem_wait_cyc%0d: got %b want %b", i, ctl, exp); end
    end
    checks++;
    if (stall_cycles !== 4'd6 || flush_events !== 4'd2 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL mem_wait_counts: sc=%0d fe=%0d to=%b want 6/2/0", stall_cycles, flush_events, mem_timeout);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      mem_req = 1; mem_ready = 0;
      #1;
      checks++;
      if (ctl !== ((i < 8) ? C_HOLD : C_BUB)) begin
        errors++;
        $display("FAIL timeout_cyc%0d: got %b want %b", i, ctl, (i < 8) ? C_HOLD : C_BUB);
      end
      checks++;
      if (mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early_cyc%0d: got %b want 0", i, mem_timeout); end
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (mem_timeout !== 1'b1 || ctl !== C_NONE) begin
      errors++; $display("FAIL timeout_sticky: to=%b ctl=%b want 1/%b", mem_timeout, ctl, C_NONE);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mem_timeout !== 1'b1 || stall_cycles !== 4'd14) begin
      errors++; $display("FAIL timeout_persist: to=%b sc=%0d want 1/14", mem_timeout, stall_cycles);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    ex_MemRead = 1; ex_RegWrite = 1; ex_rd_address = 12;
    id_rs2_address = 12; id_uses_rs2 = 1;
    repeat (4) @(negedge clk);
    idle();
    #1;
    checks++;
    if (stall_cycles !== 4'hF) begin errors++; $display("FAIL saturate: got %0d want 15", stall_cycles); end
  endtask

  task automatic test_reset_in_flush();
    @(negedge clk);
    ex_branch_taken = 1;
    @(negedge clk);
    ex_branch_taken = 0;
    #1;
    checks++;
    if (ctl !== C_FL) begin errors++; $display("FAIL rif_in_flush: got %b want %b", ctl, C_FL); end
    reset = 1;
    #1;
    checks++;
    if (ctl !== C_NONE) begin errors++; $display("FAIL rif_during: got %b want %b", ctl, C_NONE); end
    @(negedge clk);
    reset = 0;
    #1;
    checks++;
    if (ctl !== C_NONE || stall_cycles !== '0 || flush_events !== '0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rif_after: ctl=%b sc=%0d fe=%0d to=%b want 0", ctl, stall_cycles, flush_events, mem_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturate();
    test_reset_in_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Detects load-use hazards, taken-branch redirects and data-memory wait states.
- Drives the stall, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Keeps a memory-timeout watchdog and saturating performance counters. Sits beside the pipeline registers in the top-level datapath.

Parameters:
- BRANCH_PENALTY, 1, total cycles IF/ID is flushed per taken branch (1..15); cycles after the first are handled in state FLUSH.
- MEM_TIMEOUT, 64, maximum consecutive cycles memory may hold the pipeline (2..255).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- id_rs1_address  in  5  rs1 of the instruction in ID
- id_rs2_address  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd_address  in  5  destination register of the instruction in EX
- ex_MemRead  in  1  EX instruction is a load
- ex_RegWrite  in  1  EX instruction writes the register file
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- mem_req  in  1  MEM instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  load bubble into IF/ID
- idex_stall  out  1  hold ID/EX
- idex_flush  out  1  load bubble into ID/EX (all control bits 0)
- exmem_stall  out  1  hold EX/MEM
- memwb_bubble  out  1  MEM/WB captures RegWrite=0, MemtoReg=0
- mem_timeout  out  1  sticky: the watchdog fired
- stall_cycles  out  CNT_W  cycles with pc_stall=1 (saturating)
- flush_events  out  CNT_W  taken branches acted on (saturating)

Behaviour:
- Reset: synchronous on rising clk while reset=1. Result: state=RUN, flush_cnt=0, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_events=0.
- While reset=1, all stall, flush and bubble outputs are 0.
- Control outputs are combinational from registered state and current inputs. They have zero latency and act on the same edge.
- Internal terms:
  - load_use = ex_MemRead & ex_RegWrite & (ex_rd_address!=0) & ((id_uses_rs1 & id_rs1_address==ex_rd_address) | (id_uses_rs2 & id_rs2_address==ex_rd_address)).
  - mem_wait = mem_req & ~mem_ready.
  - mem_hold = mem_wait & (wait_cnt < MEM_TIMEOUT).
- Priority: mem_hold > ex_branch_taken > FLUSH state > load_use.
  - mem_hold: pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_bubble all 1; flushes 0. A pending branch or load-use is deferred, because the frozen stages keep presenting it.
  - Branch: ifid_flush=1, idex_flush=1, no stalls. flush_events increments. If BRANCH_PENALTY>1: state goes to FLUSH with flush_cnt=BRANCH_PENALTY-1; otherwise state stays RUN.
  - FLUSH state (no mem_hold, no branch): ifid_flush=1. flush_cnt decrements; when it reaches 1, the next state is RUN. A new branch in FLUSH reloads flush_cnt.
  - load_use: pc_stall=1, ifid_stall=1, idex_flush=1 for exactly one cycle. The bubble removes the hazard the next cycle, so no extra state is needed.
  - Otherwise all control outputs are 0.
- Watchdog:
  - wait_cnt increments (saturating at MEM_TIMEOUT) every cycle mem_wait=1. It clears to 0 when mem_wait=0.
  - On the first cycle with wait_cnt==MEM_TIMEOUT, mem_hold drops and the pipeline advances. memwb_bubble=1 on that cycle suppresses writeback. mem_timeout is set and stays set until reset.
- Counters increment by 1 on cycles where the condition is true and hold at all-ones.

Test Plan:
- Load x5 in EX; ID add with rs1=5, id_uses_rs1=1 -> exactly 1 cycle of pc_stall=ifid_stall=idex_flush=1; then all 0; stall_cycles=1.
- Load with ex_rd_address=0 matching id_rs1_address=0 -> no stall; all controls 0.
- BRANCH_PENALTY=3; ex_branch_taken one cycle -> cycle 0: ifid_flush=idex_flush=1; cycles 1–2: ifid_flush only; then RUN; flush_events=1.
- mem_req=1, mem_ready=0 for 4 cycles, then 1 -> all four stalls and memwb_bubble high for 4 cycles, released on the ready cycle; stall_cycles=4. A simultaneous ex_branch_taken is flushed only on the release cycle.
- MEM_TIMEOUT=8; mem_ready stuck 0 -> hold for 8 cycles; 9th cycle releases with memwb_bubble=1; mem_timeout=1 persists after mem_req drops.
- Reset asserted in FLUSH with counters nonzero -> next edge: RUN, counters 0, mem_timeout 0, outputs 0.
